// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
//
// Multi-cycle control sequencer for the TiniSOC core. It steps the datapath
// through FETCH / DECODE / EXECUTE / MEMACCESS / WRITEBACK / PCUPDATE. Phases
// that an instruction class does not need are skipped. The sequencer waits on
// the instruction- and data-memory ready handshakes. If a memory request waits
// too long, it traps.
//
// Ports
//   clock            in   rising-edge clock
//   reset            in   asynchronous, active-high reset
//   run              in   permission to start / continue fetching
//   instruction      in   instruction-memory read data (INSTR_W)
//   imem_ready       in   instruction data valid this cycle (sampled in FETCH)
//   dmem_ready       in   data access complete this cycle (sampled in MEM)
//   imem_req         out  instruction fetch request (FETCH)
//   dmem_req         out  data access request (MEM)
//   dmem_we          out  data access is a store (qualified by dmem_req)
//   enable_decode    out  decode phase enable
//   enable_execute   out  execute phase enable
//   enable_writeback out  writeback phase enable
//   enable_pc        out  PC update phase enable
//   instr_q          out  latched current instruction (INSTR_W)
//   state            out  encoded current state (IDLE=0 .. TRAP=7)
//   instr_count      out  retired-instruction counter (CNT_W, wraps)
//   bus_error        out  sticky memory-timeout trap flag
// -----------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int               INSTR_W    = 32,
    parameter int               OPC_LSB    = 25,
    parameter int               OPC_W      = 6,
    parameter logic [OPC_W-1:0] OP_BASE    = 6'b100000,
    parameter logic [OPC_W-1:0] OP_ADDI    = 6'b101000,
    parameter logic [OPC_W-1:0] OP_ORI     = 6'b101100,
    parameter logic [OPC_W-1:0] OP_XORI    = 6'b101011,
    parameter logic [OPC_W-1:0] OP_MOVI    = 6'b100010,
    parameter logic [OPC_W-1:0] OP_LWI     = 6'b000010,
    parameter logic [OPC_W-1:0] OP_SWI     = 6'b001010,
    parameter logic [OPC_W-1:0] OP_LS      = 6'b011100,
    parameter logic [OPC_W-1:0] OP_B       = 6'b100110,
    parameter logic [OPC_W-1:0] OP_JJ      = 6'b100100,
    parameter int               WAIT_LIMIT = 16,
    parameter int               WAIT_W     = 5,
    parameter int               CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               enable_decode,
    output logic               enable_execute,
    output logic               enable_writeback,
    output logic               enable_pc,
    output logic [INSTR_W-1:0] instr_q,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   instr_count,
    output logic               bus_error
);

    localparam logic [7:0] SUB_LW = 8'h02;
    localparam logic [7:0] SUB_SW = 8'h0A;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT_C = WAIT_W'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUP   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_OTHER = 3'd0,
        C_ALU   = 3'd1,
        C_LOAD  = 3'd2,
        C_STORE = 3'd3,
        C_CTRL  = 3'd4
    } class_t;

    state_t             state_q, state_d;
    class_t             class_q, class_d;
    logic [INSTR_W-1:0] instr_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               bus_error_q, bus_error_d;

    logic [OPC_W-1:0]   opcode;
    logic [7:0]         subop;
    logic [WAIT_W-1:0]  wait_inc;
    logic               wait_expired;

    assign opcode       = instr_q[OPC_LSB +: OPC_W];
    assign subop        = instr_q[7:0];
    assign wait_inc     = wait_q + 1'b1;
    // True on the WAIT_LIMIT-th consecutive cycle without ready.
    assign wait_expired = (wait_inc == WAIT_LIMIT_C);

    function automatic class_t classify(input logic [OPC_W-1:0] opc,
                                        input logic [7:0]       sub);
        class_t c;
        c = C_OTHER;
        if (opc == OP_BASE || opc == OP_ADDI || opc == OP_ORI ||
            opc == OP_XORI || opc == OP_MOVI) begin
            c = C_ALU;
        end else if (opc == OP_LWI || (opc == OP_LS && sub == SUB_LW)) begin
            c = C_LOAD;
        end else if (opc == OP_SWI || (opc == OP_LS && sub == SUB_SW)) begin
            c = C_STORE;
        end else if (opc == OP_B || opc == OP_JJ) begin
            c = C_CTRL;
        end
        return c;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            class_q     <= C_OTHER;
            instr_q     <= '0;
            wait_q      <= '0;
            count_q     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            class_q     <= class_d;
            instr_q     <= instr_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        instr_d     = instr_q;
        wait_d      = wait_q;
        count_d     = count_q;
        bus_error_d = bus_error_q;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                // A ready in the same cycle the limit is reached still wins.
                if (imem_ready) begin
                    instr_d = instruction;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_inc;
                    if (wait_expired) begin
                        state_d     = S_TRAP;
                        bus_error_d = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                class_d = classify(opcode, subop);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (class_q)
                    C_LOAD, C_STORE: begin
                        state_d = S_MEM;
                        wait_d  = '0;
                    end
                    C_ALU:   state_d = S_WB;
                    default: state_d = S_PCUP;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = (class_q == C_LOAD) ? S_WB : S_PCUP;
                end else begin
                    wait_d = wait_inc;
                    if (wait_expired) begin
                        state_d     = S_TRAP;
                        bus_error_d = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = S_PCUP;
            end
            S_PCUP: begin
                count_d = count_q + 1'b1;
                if (run) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode: every enable/request depends only on registered state.
    always_comb begin
        imem_req         = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        enable_decode    = 1'b0;
        enable_execute   = 1'b0;
        enable_writeback = 1'b0;
        enable_pc        = 1'b0;
        case (state_q)
            S_FETCH:  imem_req = 1'b1;
            S_DECODE: enable_decode = 1'b1;
            S_EXEC:   enable_execute = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (class_q == C_STORE);
            end
            S_WB:     enable_writeback = 1'b1;
            S_PCUP:   enable_pc = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
//
// Directed bench for multicycle_sequencer. A driver task issues one
// instruction at a time and pushes the expected phase trace onto a
// scoreboard. The trace is written as an octal literal with one digit per
// cycle's state code. A monitor rebuilds the trace from the DUT state
// output. It compares the trace at every PCUP cycle. The retired-count width
// is reduced so that the wrap case stays short.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int INSTR_W = 32;
    localparam int CNT_W   = 10;

    logic               clock;
    logic               reset;
    logic               run;
    logic [INSTR_W-1:0] instruction;
    logic               imem_ready;
    logic               dmem_ready;
    logic               imem_req;
    logic               dmem_req;
    logic               dmem_we;
    logic               enable_decode;
    logic               enable_execute;
    logic               enable_writeback;
    logic               enable_pc;
    logic [INSTR_W-1:0] instr_q;
    logic [2:0]         state;
    logic [CNT_W-1:0]   instr_count;
    logic               bus_error;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .run              (run),
        .instruction      (instruction),
        .imem_ready       (imem_ready),
        .dmem_ready       (dmem_ready),
        .imem_req         (imem_req),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_pc        (enable_pc),
        .instr_q          (instr_q),
        .state            (state),
        .instr_count      (instr_count),
        .bus_error        (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction encodings.
    localparam logic [31:0] I_ADD   = 32'h4000_0000;      // 100000 << 25
    localparam logic [31:0] I_ADDI  = 32'h5000_0123;      // 101000 << 25
    localparam logic [31:0] I_ORI   = 32'h5800_0042;      // 101100 << 25
    localparam logic [31:0] I_LWI   = 32'h0400_0010;      // 000010 << 25
    localparam logic [31:0] I_SWI   = 32'h1400_0020;      // 001010 << 25
    localparam logic [31:0] I_LS_LW = 32'h3800_0002;      // 011100 << 25, LW
    localparam logic [31:0] I_LS_SW = 32'h3800_000A;      // 011100 << 25, SW
    localparam logic [31:0] I_LS_X  = 32'h3800_0055;      // bad subop
    localparam logic [31:0] I_B     = 32'h4C00_0000;      // 100110 << 25
    localparam logic [31:0] I_JJ    = 32'h4800_0000;      // 100100 << 25
    localparam logic [31:0] I_NOP   = 32'h0000_0000;

    typedef struct {
        logic [63:0]      trace;
        bit               we;
        bit               wb;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_cnt;
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: rebuild the phase trace and compare at each retirement.
    logic [63:0] mon_trace = '0;
    bit          mon_we = 0;
    bit          mon_wb = 0;
    logic [2:0]  mon_prev = 3'd0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            mon_trace = '0;
            mon_we    = 0;
            mon_wb    = 0;
        end else begin
            chk("onehot", 64'($countones({imem_req, dmem_req, enable_decode,
                                          enable_execute, enable_writeback,
                                          enable_pc}) <= 1), 64'd1);
            if (state == 3'd1 && mon_prev != 3'd1) begin
                mon_trace = '0;
                mon_we    = 0;
                mon_wb    = 0;
            end
            if (state != 3'd0 && state != 3'd7)
                mon_trace = (mon_trace << 3) | 64'(state);
            if (dmem_req && dmem_we) mon_we = 1;
            if (enable_writeback)    mon_wb = 1;
            if (state == 3'd6) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("trace", mon_trace, e.trace);
                    chk("store_we", 64'(mon_we), 64'(e.we));
                    chk("writeback_seen", 64'(mon_wb), 64'(e.wb));
                    chk("instr_count", 64'(instr_count), 64'(e.cnt));
                    chk("enable_pc", 64'(enable_pc), 64'd1);
                end
            end
        end
        mon_prev = state;
    end

    // Issue one instruction; imem/dmem ready arrive after id/dd wait cycles.
    // Outside their own phase the ready lines are driven high to show they are ignored.
    task automatic exec(input logic [31:0] ins, input int id, input int dd,
                        input logic [63:0] tr, input bit we, input bit wb,
                        input bit drop_run);
        exp_t e;
        int   fc;
        int   mc;
        bit   done;
        e.trace = tr;
        e.we    = we;
        e.wb    = wb;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        exp_cnt++;
        instruction = ins;
        fc = 0;
        mc = 0;
        done = 0;
        for (int g = 0; g < 100 && !done; g++) begin
            @(negedge clock);
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            if (state == 3'd1) begin
                imem_ready = (fc >= id);
                fc++;
            end
            if (state == 3'd4) begin
                dmem_ready = (mc >= dd);
                mc++;
            end
            if (state == 3'd3 && drop_run) run = 1'b0;
            if (state == 3'd6) done = 1;
        end
        if (!done) chk("exec_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int g;
        g = 0;
        while (state != s && g < 50) begin
            @(negedge clock);
            g++;
        end
        chk(name, 64'(state), 64'(s));
    endtask

    initial begin
        int fc;
        reset       = 1'b1;
        run         = 1'b0;
        instruction = '0;
        imem_ready  = 1'b0;
        dmem_ready  = 1'b0;
        exp_cnt     = '0;
        repeat (2) @(negedge clock);

        // Reset state.
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_outputs", 64'({imem_req, dmem_req, dmem_we, enable_decode,
                                enable_execute, enable_writeback, enable_pc}), 64'd0);
        chk("rst_instr_q", 64'(instr_q), 64'd0);
        chk("rst_count", 64'(instr_count), 64'd0);
        chk("rst_bus_error", 64'(bus_error), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle_no_run", 64'(state), 64'd0);

        // Instruction classes and wait states.
        run = 1'b1;
        exec(I_ADD,   0, 0, 64'o12356,     0, 1, 0);
        exec(I_ADDI,  2, 0, 64'o1112356,   0, 1, 0);
        exec(I_LWI,   0, 3, 64'o123444456, 0, 1, 0);
        exec(I_LS_SW, 0, 0, 64'o12346,     1, 0, 0);
        exec(I_LS_LW, 0, 1, 64'o1234456,   0, 1, 0);
        exec(I_SWI,   0, 0, 64'o12346,     1, 0, 0);
        exec(I_LS_X,  0, 0, 64'o1236,      0, 0, 0);
        exec(I_JJ,    0, 0, 64'o1236,      0, 0, 0);
        // Ready on the last allowed fetch cycle: no trap.
        exec(I_ADD,  15, 0, 64'o11111111111111112356, 0, 1, 0);
        chk("limit_ready_no_error", 64'(bus_error), 64'd0);

        // run dropped during EXEC: the branch completes, then the block idles.
        exec(I_B, 0, 0, 64'o1236, 0, 0, 1);
        repeat (3) @(negedge clock);
        chk("idle_after_drop", 64'(state), 64'd0);
        chk("idle_no_req", 64'(imem_req), 64'd0);
        run = 1'b1;
        exec(I_ORI, 0, 0, 64'o12356, 0, 1, 0);
        chk("instr_q_latched", 64'(instr_q), 64'(I_ORI));

        // Fetch timeout trap.
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        exp_cnt = '0;
        @(negedge clock);
        reset      = 1'b0;
        imem_ready = 1'b0;
        run        = 1'b1;
        wait_state(3'd1, "trap_enter_fetch");
        fc = 0;
        while (state == 3'd1 && fc < 40) begin
            fc++;
            @(negedge clock);
        end
        chk("trap_fetch_cycles", 64'(fc), 64'd16);
        chk("trap_state", 64'(state), 64'd7);
        chk("trap_bus_error", 64'(bus_error), 64'd1);
        imem_ready = 1'b1;
        repeat (5) @(negedge clock);
        chk("trap_held", 64'(state), 64'd7);
        chk("trap_no_req", 64'(imem_req), 64'd0);
        chk("trap_count_frozen", 64'(instr_count), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("trap_reset_state", 64'(state), 64'd0);
        chk("trap_reset_bus_error", 64'(bus_error), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Asynchronous reset during a stalled load.
        exec(I_ADD, 0, 0, 64'o12356, 0, 1, 0);
        instruction = I_LWI;
        imem_ready  = 1'b1;
        dmem_ready  = 1'b0;
        wait_state(3'd4, "stall_in_mem");
        chk("stall_dmem_req", 64'(dmem_req), 64'd1);
        chk("stall_count", 64'(instr_count), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_state", 64'(state), 64'd0);
        chk("async_dmem_req", 64'(dmem_req), 64'd0);
        chk("async_instr_q", 64'(instr_q), 64'd0);
        chk("async_count", 64'(instr_count), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        exp_cnt = '0;

        // Retired counter wraps after 2**CNT_W instructions.
        run = 1'b1;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            exec(I_NOP, 0, 0, 64'o1236, 0, 0, 0);
        end
        @(negedge clock);
        chk("count_wrap", 64'(instr_count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
